// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// PIPELINED_BARREL_SHIFTER_STATUS_EN adds a carry bit to the stage sideband.
package shifter_pkg;

   localparam int MAX_WIDTH = 64;
   localparam int MAX_SHW   = 6;

   typedef enum logic [1:0] {
      SLL = 2'b00,
      SRL = 2'b01,
      SRA = 2'b10,
      ROR = 2'b11
   } shift_op_t;

   // Sideband carried alongside the data in every stage register.
   typedef struct packed {
      shift_op_t          op;
      logic               sign;
      logic [MAX_SHW-1:0] shamt;
`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
      logic               carry;
`endif
   } stage_side_t;

   function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] value,
                                                        input int width);
      logic [MAX_WIDTH-1:0] result;
      result = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) begin
            result[i] = value[width-1-i];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One mux layer (shift right by 2^LAYER) plus its pipeline register.
// PIPELINED_BARREL_SHIFTER_STATUS_EN enables carry tracking through the layer.
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LAYER = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   input  logic [WIDTH-1:0]  i_data,
   input  stage_side_t       i_side,
   input  logic              i_nextAdvance,
   output logic              o_advance,
   output logic              o_valid,
   output logic [WIDTH-1:0]  o_data,
   output stage_side_t       o_side
);

   localparam int STEP = 1 << LAYER;

   logic              r_valid;
   logic [WIDTH-1:0]  r_data;
   stage_side_t       r_side;

   logic              w_apply;
   logic [STEP-1:0]   w_fill;
   logic [WIDTH-1:0]  w_shifted;
   stage_side_t       w_sideNext;

   assign w_apply = i_side.shamt[LAYER];

   always_comb begin
      w_fill = '0;
      case (i_side.op)
         SRA:     w_fill = {STEP{i_side.sign}};
         ROR:     w_fill = i_data[STEP-1:0];
         default: w_fill = '0;
      endcase
   end

   // The last bit leaving the low end at the highest applied layer is the final carry.
   always_comb begin
      w_shifted  = i_data;
      w_sideNext = i_side;
      if (w_apply) begin
         w_shifted = {w_fill, i_data[WIDTH-1:STEP]};
`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
         w_sideNext.carry = i_data[STEP-1];
`endif
      end
   end

   assign o_advance = !r_valid || i_nextAdvance;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_side  <= '0;
      end else if (o_advance) begin
         r_valid <= i_valid;
         r_data  <= w_shifted;
         r_side  <= w_sideNext;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_side  = r_side;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter (SLL/SRL/SRA/ROR), one mux layer per stage.
// Optional status outputs out_zero/out_carry under PIPELINED_BARREL_SHIFTER_STATUS_EN.
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  logic [1:0]               in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_result
`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
   ,
   output logic                     out_zero,
   output logic                     out_carry
`endif
);

   localparam int SHW = $clog2(WIDTH);

   shift_op_t             w_inOp;
   logic [MAX_WIDTH-1:0]  w_inRev;
   logic [MAX_WIDTH-1:0]  w_outRev;
   logic [WIDTH-1:0]      w_data0;
   stage_side_t           w_side0;

   logic                  w_valid [SHW];
   logic                  w_adv   [SHW];
   logic [WIDTH-1:0]      w_data  [SHW];
   stage_side_t           w_side  [SHW];

   assign w_inOp  = shift_op_t'(in_op);
   assign w_inRev = bit_reverse(MAX_WIDTH'(in_a), WIDTH);
   // Left shifts run through the right-shift datapath on the mirrored operand.
   assign w_data0 = (w_inOp == SLL) ? w_inRev[WIDTH-1:0] : in_a;

   always_comb begin
      w_side0       = '0;
      w_side0.op    = w_inOp;
      w_side0.sign  = in_a[WIDTH-1];
      w_side0.shamt = MAX_SHW'(in_shamt);
   end

   for (genvar g = 0; g < SHW; g++) begin : g_stage
      logic              w_vIn;
      logic [WIDTH-1:0]  w_dIn;
      stage_side_t       w_sIn;
      logic              w_nextAdv;

      if (g == 0) begin : g_first
         assign w_vIn = in_valid;
         assign w_dIn = w_data0;
         assign w_sIn = w_side0;
      end else begin : g_chain
         assign w_vIn = w_valid[g-1];
         assign w_dIn = w_data[g-1];
         assign w_sIn = w_side[g-1];
      end

      if (g == SHW - 1) begin : g_last
         assign w_nextAdv = out_ready;
      end else begin : g_mid
         assign w_nextAdv = w_adv[g+1];
      end

      shifter_stage #(
         .WIDTH (WIDTH),
         .LAYER (g)
      ) u_stage (
         .clk           (clk),
         .reset         (reset),
         .i_valid       (w_vIn),
         .i_data        (w_dIn),
         .i_side        (w_sIn),
         .i_nextAdvance (w_nextAdv),
         .o_advance     (w_adv[g]),
         .o_valid       (w_valid[g]),
         .o_data        (w_data[g]),
         .o_side        (w_side[g])
      );
   end

   assign in_ready  = w_adv[0];
   assign out_valid = w_valid[SHW-1];
   assign w_outRev  = bit_reverse(MAX_WIDTH'(w_data[SHW-1]), WIDTH);
   assign out_result = (w_side[SHW-1].op == SLL) ? w_outRev[WIDTH-1:0] : w_data[SHW-1];

`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
   assign out_zero  = out_valid && (out_result == '0);
   assign out_carry = out_valid && w_side[SHW-1].carry;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: a 32-bit and an 8-bit instance
// run directed and random traffic against a behavioural shift model.
module tb_pipelined_barrel_shifter;

   localparam int SHW32 = 5;
   localparam int N32   = 6000;
   localparam int N8    = 6000;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_a, out_result;
   logic [4:0]  in_shamt;
   logic [1:0]  in_op;

   logic        reset8;
   logic        inValid8, inReady8, outValid8, outReady8;
   logic [7:0]  inA8, outResult8;
   logic [2:0]  inShamt8;
   logic [1:0]  inOp8;

`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
   logic out_zero, out_carry, outZero8, outCarry8;
`endif

   int          checks = 0;
   int          errors = 0;
   int          consumeCount32 = 0;
   logic        done8 = 1'b0;
   logic [32:0] q32[$];
   logic [8:0]  q8[$];

   always #5 clk = ~clk;

   pipelined_barrel_shifter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
      , .out_zero(out_zero), .out_carry(out_carry)
`endif
   );

   pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset8), .in_valid(inValid8), .in_ready(inReady8),
      .in_a(inA8), .in_shamt(inShamt8), .in_op(inOp8),
      .out_valid(outValid8), .out_ready(outReady8), .out_result(outResult8)
`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
      , .out_zero(outZero8), .out_carry(outCarry8)
`endif
   );

   // Reference: plain arithmetic on a w-bit value; returns {carry, result}.
   function automatic logic [64:0] refShift(input int w, input logic [63:0] a,
                                            input int s, input logic [1:0] op);
      logic [63:0] mask, r;
      logic        c;
      mask = (64'd1 << w) - 64'd1;
      a    = a & mask;
      case (op)
         2'd0: r = (a << s) & mask;
         2'd1: r = a >> s;
         2'd2: r = a[w-1] ? ((a >> s) | (mask & ~(mask >> s))) : (a >> s);
         default: r = ((a >> s) | (a << (w - s))) & mask;
      endcase
      if (s == 0)        c = 1'b0;
      else if (op == 2'd0) c = a[w-s];
      else               c = a[s-1];
      return {c, r};
   endfunction

   function automatic logic [32:0] exp32(input logic [31:0] a, input int s, input logic [1:0] op);
      logic [64:0] e;
      e = refShift(32, 64'(a), s, op);
      return {e[64], e[31:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [4:0] s,
                                input logic [1:0] op, input logic rdy, input logic [32:0] e,
                                output logic acc);
      @(negedge clk);
      in_valid  = v;
      in_a      = a;
      in_shamt  = s;
      in_op     = op;
      out_ready = rdy;
      #1;
      acc = v && in_ready;
      if (acc) q32.push_back(e);
   endtask

   task automatic sendDirected(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op,
                               input logic [31:0] res, input logic c);
      logic acc;
      int   tries;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         applyStimulus(1'b1, a, s, op, 1'b1, {c, res}, acc);
         tries++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("[TB] FAIL sendDirected: not accepted after %0d cycles, expected acceptance", tries);
      end
   endtask

   task automatic drain32(input int bound);
      logic acc;
      int   n;
      n = 0;
      while (q32.size() != 0 && n < bound) begin
         applyStimulus(1'b0, 32'h0, 5'd0, 2'd0, 1'b1, 33'h0, acc);
         #2;
         n++;
      end
      checkOutput("drain32", 64'(q32.size()), 64'd0);
   endtask

   // Monitor for the 32-bit instance: scoreboard pop plus hold-under-stall check.
   logic        prevStall = 1'b0;
   logic [31:0] prevResult;
   always @(negedge clk) begin
      logic [32:0] e;
      #2;
      if (reset) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checks++;
            if (!out_valid || out_result !== prevResult) begin
               errors++;
               $display("[TB] FAIL stallHold: valid=%0b result=%h, expected valid=1 result=%h",
                        out_valid, out_result, prevResult);
            end
         end
         if (out_valid && out_ready) begin
            consumeCount32++;
            checks++;
            if (q32.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected32: result %h appeared, expected no output", out_result);
            end else begin
               e = q32.pop_front();
               if (out_result !== e[31:0]) begin
                  errors++;
                  $display("[TB] FAIL result32: got %h, expected %h", out_result, e[31:0]);
               end
`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
               checkOutput("carry32", 64'(out_carry), 64'(e[32]));
               checkOutput("zero32", 64'(out_zero), 64'(e[31:0] == 32'h0));
`endif
            end
         end
         prevStall  = out_valid && !out_ready;
         prevResult = out_result;
      end
   end

   always @(negedge clk) begin
      logic [8:0] e;
      #2;
      if (!reset8 && outValid8 && outReady8) begin
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected8: result %h appeared, expected no output", outResult8);
         end else begin
            e = q8.pop_front();
            if (outResult8 !== e[7:0]) begin
               errors++;
               $display("[TB] FAIL result8: got %h, expected %h", outResult8, e[7:0]);
            end
`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
            checkOutput("carry8", 64'(outCarry8), 64'(e[8]));
`endif
         end
      end
   end

   // 8-bit instance: independent random stream with random backpressure.
   initial begin : stream8
      logic [64:0] e;
      logic [7:0]  a8;
      int          s8, sent8, cyc8, n;
      logic [1:0]  o8;
      logic        pend8;
      reset8 = 1'b1; inValid8 = 1'b0; inA8 = '0; inShamt8 = '0; inOp8 = '0; outReady8 = 1'b0;
      pend8 = 1'b0; sent8 = 0; cyc8 = 0; a8 = '0; s8 = 0; o8 = '0;
      repeat (3) @(negedge clk);
      reset8 = 1'b0;
      while (sent8 < N8 && cyc8 < 40000) begin
         @(negedge clk);
         if (!pend8) begin
            a8    = 8'($urandom);
            s8    = int'($urandom_range(0, 7));
            o8    = 2'($urandom_range(0, 3));
            pend8 = ($urandom_range(0, 3) != 0);
         end
         inValid8  = pend8;
         inA8      = a8;
         inShamt8  = 3'(s8);
         inOp8     = o8;
         outReady8 = 1'($urandom_range(0, 1));
         #1;
         if (pend8 && inReady8) begin
            e = refShift(8, 64'(a8), s8, o8);
            q8.push_back({e[64], e[7:0]});
            sent8++;
            pend8 = 1'b0;
         end
         cyc8++;
      end
      n = 0;
      while (q8.size() != 0 && n < 50) begin
         @(negedge clk);
         inValid8  = 1'b0;
         outReady8 = 1'b1;
         #3;
         n++;
      end
      checkOutput("sent8", 64'(sent8), 64'(N8));
      checkOutput("drain8", 64'(q8.size()), 64'd0);
      done8 = 1'b1;
   end

   initial begin : main32
      logic        acc;
      int          lat, idx, start, cyc, sent, n;
      logic [31:0] bpA [20];
      logic [4:0]  bpS [20];
      logic [1:0]  bpOp[20];
      logic [32:0] bpE [20];
      logic [31:0] ra;
      int          rs;
      logic [1:0]  ro;
      logic        pending;

      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_shamt = '0; in_op = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #3;
      checkOutput("rstOutValid", 64'(out_valid), 64'd0);
      checkOutput("rstInReady", 64'(in_ready), 64'd1);
      checkOutput("rstResult", 64'(out_result), 64'd0);
`ifdef PIPELINED_BARREL_SHIFTER_STATUS_EN
      checkOutput("rstZero", 64'(out_zero), 64'd0);
      checkOutput("rstCarry", 64'(out_carry), 64'd0);
`endif

      $display("[TB] directed operations");
      applyStimulus(1'b1, 32'h8000_0000, 5'd4, 2'b10, 1'b1, {1'b0, 32'hF800_0000}, acc);
      checkOutput("latAccept", 64'(acc), 64'd1);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #3;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      checkOutput("latency", 64'(lat), 64'(SHW32));
      drain32(20);

      sendDirected(32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 1'b0);
      sendDirected(32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0);
      sendDirected(32'h8000_0001, 5'd1,  2'b00, 32'h0000_0002, 1'b1);
      sendDirected(32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F, 1'b0);
      sendDirected(32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 1'b0);
      sendDirected(32'h7000_0000, 5'd4,  2'b10, 32'h0700_0000, 1'b0);
      sendDirected(32'h0000_000F, 5'd4,  2'b01, 32'h0000_0000, 1'b1);
      sendDirected(32'hFFFF_FFFF, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b1);
      drain32(40);

      $display("[TB] backpressure");
      for (int i = 0; i < 20; i++) begin
         bpA[i]  = $urandom;
         bpS[i]  = 5'($urandom_range(0, 31));
         bpOp[i] = 2'($urandom_range(0, 3));
         bpE[i]  = exp32(bpA[i], int'(bpS[i]), bpOp[i]);
      end
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, bpA[idx], bpS[idx], bpOp[idx], 1'b0, bpE[idx], acc);
         if (acc) idx++;
      end
      checkOutput("bpAccepted", 64'(idx), 64'(SHW32));
      checkOutput("bpInReady", 64'(in_ready), 64'd0);
      checkOutput("bpOutValid", 64'(out_valid), 64'd1);
      checkOutput("bpHold", 64'(out_result), 64'(bpE[0][31:0]));
      start = consumeCount32;
      cyc = 0;
      while (consumeCount32 - start < 20 && cyc < 100) begin
         if (idx < 20) applyStimulus(1'b1, bpA[idx], bpS[idx], bpOp[idx], 1'b1, bpE[idx], acc);
         else          applyStimulus(1'b0, 32'h0, 5'd0, 2'd0, 1'b1, 33'h0, acc);
         if (acc) idx++;
         cyc++;
         #2;
      end
      checkOutput("bpDrainCycles", 64'(cyc), 64'd20);
      drain32(20);

      $display("[TB] reset mid-flight");
      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         applyStimulus(1'b1, ra, 5'd3, 2'b01, 1'b0, exp32(ra, 3, 2'b01), acc);
      end
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_a      = 32'hDEAD_BEEF;
      out_ready = 1'b1;
      q32.delete();
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      #3;
      checkOutput("flushOutValid", 64'(out_valid), 64'd0);
      checkOutput("flushInReady", 64'(in_ready), 64'd1);
      repeat (12) applyStimulus(1'b0, 32'h0, 5'd0, 2'd0, 1'b1, 33'h0, acc);

      $display("[TB] random traffic");
      sent = 0; cyc = 0; pending = 1'b0; ra = '0; rs = 0; ro = '0;
      while (sent < N32 && cyc < 40000) begin
         if (!pending) begin
            ra      = $urandom;
            rs      = int'($urandom_range(0, 31));
            ro      = 2'($urandom_range(0, 3));
            pending = ($urandom_range(0, 3) != 0);
         end
         applyStimulus(pending, ra, 5'(rs), ro, 1'($urandom_range(0, 1)), exp32(ra, rs, ro), acc);
         if (acc) begin
            sent++;
            pending = 1'b0;
         end
         cyc++;
      end
      checkOutput("sent32", 64'(sent), 64'(N32));
      drain32(50);

      n = 0;
      while (!done8 && n < 50000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done8", 64'(done8), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter with one mux layer per pipeline stage.
- Supports logical-left, logical-right, arithmetic-right and rotate-right on WIDTH-bit operands.
- Uses a valid/ready handshake with full backpressure.
- Sits between the ALU operand registers and the ALU result mux; throughput is one operation per cycle.

Parameters:
- WIDTH, 32, operand width in bits; power of two, 4..64.
- SHW, $clog2(WIDTH), shift-amount width; also the number of mux layers and pipeline stages. Derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept the input beat this cycle
- in_a  input  WIDTH  operand to shift
- in_shamt  input  SHW  shift amount, 0..WIDTH-1
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result this cycle
- out_result  output  WIDTH  shifted result

Behaviour:
- Transfer rule: an input is accepted when in_valid && in_ready at a rising edge. A result is consumed when out_valid && out_ready.
- Right-shift datapath: all work is done as right shifts.
  - For SLL, in_a is bit-reversed before layer 0.
  - For SLL, the stage SHW-1 output is bit-reversed before it drives out_result.
- Fill source per layer k (shift by 2^k when shamt bit k is 1):
  - SLL/SRL: fill with 0.
  - SRA: fill with the captured sign bit, in_a[WIDTH-1] at acceptance.
  - ROR: fill with the bits shifted out of the low end.
- Sideband: op, sign and the remaining shamt bits travel with the data in each stage register.
- Stage k register holds the result after layers 0..k.
- Latency: out_valid rises exactly SHW cycles after acceptance when no stall occurs. For WIDTH=32 this is 5.
- Stage flow control:
  - Stage k advances when its valid is 0, or when stage k+1 advances. The last stage advances on out_ready.
  - in_ready = stage 0 advance condition, combinational from out_ready through the valid chain. There are no bubbles under continuous flow.
- Capacity: SHW results are held under a stall. Results are delivered in acceptance order; none is dropped or duplicated.
- Stability: while out_valid && !out_ready, out_result and out_valid hold stable.
- Shift amount 0 passes the operand unchanged for every op. SRA of a positive value equals SRL.
- Reset: all stage valid bits clear to 0, so out_valid=0 and in_ready=1 in the first cycle after reset.
  - Data registers reset to 0, so out_result=0.
  - Reset mid-operation discards all in-flight beats.
  - An input presented during a reset cycle is not accepted.
- Simultaneous accept and consume at a full pipeline is legal; the occupancy count is unchanged.

Optional Feature:
- Macro: PIPELINED_BARREL_SHIFTER_STATUS_EN.
- When defined, adds two outputs, both valid with out_valid and reset to 0:
  - out_zero  output 1: out_result == 0.
  - out_carry  output 1: last bit shifted or rotated out.
- out_carry tracking: at each layer k where the shift applies, carry <= cur[2^k-1] in the right-shift domain. It is 0 when shamt==0.
  - For SLL this is the original in_a[WIDTH-shamt].
  - For ROR it equals the bit that wrapped into out_result[WIDTH-1].
- When undefined, the ports and all carry/zero logic are absent.

Decomposition:
- Package shifter_pkg holds:
  - typedef shift_op_t with SLL, SRL, SRA, ROR.
  - The stage sideband struct: op, sign, remaining shamt, and carry when enabled.
  - Function bit_reverse(WIDTH).
- Sub-module shifter_stage, instantiated SHW times in a generate loop, parameter LAYER. It contains:
  - One layer's shift-by-2^LAYER mux with fill selection.
  - The stage valid/data register and its advance logic.
- The top level holds the input/output bit reversal and the handshake outputs.

Test Plan:
- SRA, in_a=0x8000_0000, shamt=4, out_ready=1 -> out_result=0xF800_0000 with out_valid exactly 5 cycles after acceptance. The same operand with SRL -> 0x0800_0000.
- SLL, 0x0000_0001, shamt=31 -> 0x8000_0000. With STATUS_EN: carry=0, zero=0. SLL 0x8000_0001, shamt=1 -> 0x0000_0002, carry=1.
- ROR, 0x0000_00F1, shamt=4 -> 0x1000_000F. ROR 0x1234_5678, shamt=0 -> 0x1234_5678, carry=0.
- Backpressure: stream 20 random ops with in_valid=1 and out_ready=0 for 10 cycles.
  - Required: exactly 5 beats accepted, then in_ready=0 and out_result stable.
  - After out_ready=1, all 20 results match the reference model in order, at one per cycle.
- Reset mid-flight: 3 beats in the pipeline, then reset asserted for 1 cycle.
  - Required: next cycle out_valid=0, in_ready=1; no stale result ever appears.
- Random out_ready toggling, 10k ops with all ops and shamts over WIDTH=8 and WIDTH=32 -> scoreboard match and no handshake violation.
